// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter_pkg
// Purpose : Shared constants and FSM state encoding for the data-memory
//           arbiter, the data memory and the loader.
// Revision: 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_IDX_W  = 8;
  localparam int DMEM_WORDS  = 256;

  // Arbiter FSM encoding; values are shared with other users of the memory
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage : data_mem_arbiter_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter_if
// Purpose : Requester handshakes (two ports) plus the single-port data-memory
//           bus. 'slave' is the arbiter view; 'master' is the environment view
//           (requesters driving req/we/addr/wdata, memory driving mem_rdata).
// Revision: 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
);

  // requester 0 (CPU load/store stage)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  // requester 1 (debug/loader port)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  // data memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output done0, err0, rdata0,
    output done1, err1, rdata1,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  done0, err0, rdata0,
    input  done1, err1, rdata1,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy
  );

endinterface : data_mem_arbiter_if
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Combinational two-way round-robin pick. A lone requester always
//           wins; on a tie the port named by rr_ptr_i wins.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic [1:0] req_i,
  input  wire logic       rr_ptr_i,
  output logic            gnt_id_o,
  output logic            any_o
);

  // Pick the winner; gnt_id_o is only meaningful while any_o is high
  always_comb begin
    any_o    = |req_i;
    gnt_id_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_id_o = rr_ptr_i;
    end else begin
      gnt_id_o = req_i[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_arbiter
// Purpose : Shares the single-port data memory between the CPU (port 0) and
//           the debug/loader port (port 1). Round-robin grant, one access in
//           flight: IDLE -> ACCESS (1 cycle strobe) -> RESP (done pulse).
//           Misaligned or out-of-range addresses skip ACCESS and answer
//           with err in RESP without touching memory.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int IDX_W  = DMEM_IDX_W
) (
  input  wire logic        clock,
  input  wire logic        reset,
  data_mem_arbiter_if.slave bus
);

  arb_state_t        state_q;
  arb_state_t        state_d;

  logic              rr_ptr_q;
  logic              gnt_id_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              w_any;
  logic              w_gnt_id;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_illegal;

  rr_arb2 u_rr_arb2 (
    .req_i    ({bus.req1, bus.req0}),
    .rr_ptr_i (rr_ptr_q),
    .gnt_id_o (w_gnt_id),
    .any_o    (w_any)
  );

  // Steer the winning port's request and classify its address
  always_comb begin
    w_sel_we    = w_gnt_id ? bus.we1    : bus.we0;
    w_sel_addr  = w_gnt_id ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_gnt_id ? bus.wdata1 : bus.wdata0;
    // word index occupies bits [IDX_W+1:2]; anything above must be zero
    w_illegal   = (w_sel_addr[1:0] != 2'b00) ||
                  ((w_sel_addr >> (IDX_W + 2)) != '0);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          state_d = w_illegal ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latches, read-data capture and round-robin pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
      gnt_id_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            gnt_id_q <= w_gnt_id;
            we_q     <= w_sel_we;
            err_q    <= w_illegal;
            addr_q   <= w_sel_addr;
            wdata_q  <= w_sel_wdata;
            // cleared so writes and rejected accesses answer with zero data
            rdata_q  <= '0;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata_q <= bus.mem_rdata;
          end
        end
        ST_RESP: begin
          // the port just served loses the next tie
          rr_ptr_q <= ~gnt_id_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory strobes from state + latched we, responses routed to the granted port
  always_comb begin
    // strobes are killed while reset is held so an aborted write never commits
    bus.mem_read  = (state_q == ST_ACCESS) && !we_q && !reset;
    bus.mem_write = (state_q == ST_ACCESS) &&  we_q && !reset;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.busy      = (state_q != ST_IDLE);

    bus.done0  = (state_q == ST_RESP) && !gnt_id_q;
    bus.done1  = (state_q == ST_RESP) &&  gnt_id_q;
    bus.err0   = bus.done0 && err_q;
    bus.err1   = bus.done1 && err_q;
    bus.rdata0 = bus.done0 ? rdata_q : '0;
    bus.rdata1 = bus.done1 ? rdata_q : '0;
  end

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_arbiter
// Purpose : Directed self-checking bench for data_mem_arbiter with a simple
//           256-word data memory model behind it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  data_mem_arbiter #(
    .DATA_W (32),
    .ADDR_W (32),
    .IDX_W  (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Data memory model: word 0 holds 5, every other word holds 0x1000 + index
  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0000_1000 + 32'(i);
      mem[0]    <= 32'd5;
      mem_ready <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : 32'h0;

  // Raise one request (caller sits on a negedge), wait for its done,
  // drop the request in the done cycle and step back to IDLE.
  task automatic run_access(input bit port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] rd, output logic er, output int strobes);
    bit seen;
    lat = -1; rd = '0; er = 1'b0; strobes = 0; seen = 1'b0;
    if (port) begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.req0 = 1'b1;
    end
    for (int i = 1; i <= 10; i++) begin
      if (!seen) begin
        @(negedge clock);
        if (bus.mem_read || bus.mem_write) strobes++;
        if ((port ? bus.done1 : bus.done0) === 1'b1) begin
          lat  = i;
          rd   = port ? bus.rdata1 : bus.rdata0;
          er   = port ? bus.err1   : bus.err0;
          seen = 1'b1;
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0)
      $display("FAIL reset_done: got %b%b want 00", bus.done1, bus.done0); else n_pass++;
    n_checks++; if (bus.err0 !== 1'b0 || bus.err1 !== 1'b0)
      $display("FAIL reset_err: got %b%b want 00", bus.err1, bus.err0); else n_pass++;
    n_checks++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0)
      $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1); else n_pass++;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0)
      $display("FAIL reset_strobes: got r=%b w=%b want 0/0", bus.mem_read, bus.mem_write); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_read();
    int lat; logic [31:0] rd; logic er; int st;
    run_access(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er, st);
    n_checks++; if (lat !== 2) $display("FAIL read_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'd5) $display("FAIL read_data: got %h want 00000005", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL read_err: got %b want 0", er); else n_pass++;
    n_checks++; if (st !== 1) $display("FAIL read_strobe_cycles: got %0d want 1", st); else n_pass++;
  endtask

  task automatic test_write_readback();
    int lat; logic [31:0] rd; logic er; int st;
    run_access(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er, st);
    n_checks++; if (lat !== 2) $display("FAIL write_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL write_err: got %b want 0", er); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL write_rdata: got %h want 00000000", rd); else n_pass++;
    n_checks++; if (st !== 1) $display("FAIL write_strobe_cycles: got %0d want 1", st); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL write_mem: got %h want deadbeef", mem[4]); else n_pass++;
    run_access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er, st);
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL readback_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL readback_latency: got %0d want 2", lat); else n_pass++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; int st;
    run_access(1'b0, 1'b0, 32'h2, 32'h0, lat, rd, er, st);
    n_checks++; if (lat !== 1) $display("FAIL misalign_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (er !== 1'b1) $display("FAIL misalign_err: got %b want 1", er); else n_pass++;
    n_checks++; if (st !== 0) $display("FAIL misalign_strobes: got %0d want 0", st); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL misalign_rdata: got %h want 00000000", rd); else n_pass++;
    run_access(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, lat, rd, er, st);
    n_checks++; if (lat !== 1) $display("FAIL range_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (er !== 1'b1) $display("FAIL range_err: got %b want 1", er); else n_pass++;
    n_checks++; if (st !== 0) $display("FAIL range_strobes: got %0d want 0", st); else n_pass++;
    n_checks++; if (mem[0] !== 32'd5) $display("FAIL range_mem_word0: got %h want 00000005", mem[0]); else n_pass++;
  endtask

  task automatic test_contention();
    int          ev_port [4];
    int          ev_cyc  [4];
    logic [31:0] ev_rd   [4];
    int          n_ev;
    int          exp_port [4];
    logic [31:0] exp_rd   [4];
    exp_port = '{0, 1, 0, 1};
    exp_rd   = '{32'd5, 32'hDEAD_BEEF, 32'd5, 32'hDEAD_BEEF};
    n_ev = 0;
    test_reset();
    bus.we0 = 1'b0; bus.addr0 = 32'h0;
    bus.we1 = 1'b0; bus.addr1 = 32'h10;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      if (bus.done0 === 1'b1 && n_ev < 4) begin
        ev_port[n_ev] = 0; ev_cyc[n_ev] = c; ev_rd[n_ev] = bus.rdata0; n_ev++;
      end
      if (bus.done1 === 1'b1 && n_ev < 4) begin
        ev_port[n_ev] = 1; ev_cyc[n_ev] = c; ev_rd[n_ev] = bus.rdata1; n_ev++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clock);
    n_checks++; if (n_ev !== 4) $display("FAIL contention_count: got %0d want 4", n_ev); else n_pass++;
    for (int k = 0; k < n_ev; k++) begin
      n_checks++; if (ev_port[k] !== exp_port[k])
        $display("FAIL contention_port[%0d]: got %0d want %0d", k, ev_port[k], exp_port[k]); else n_pass++;
      n_checks++; if (ev_cyc[k] !== 2 + 3 * k)
        $display("FAIL contention_cycle[%0d]: got %0d want %0d", k, ev_cyc[k], 2 + 3 * k); else n_pass++;
      n_checks++; if (ev_rd[k] !== exp_rd[k])
        $display("FAIL contention_rdata[%0d]: got %h want %h", k, ev_rd[k], exp_rd[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; int st;
    int first_port; int first_cyc;
    // serve port 0 so that without a reset the next tie would go to port 1
    run_access(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er, st);
    n_checks++; if (rd !== 32'd5) $display("FAIL abort_pre_read: got %h want 00000005", rd); else n_pass++;
    bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'h1234_5678; bus.req0 = 1'b1;
    @(negedge clock);
    n_checks++; if (bus.mem_write !== 1'b1) $display("FAIL abort_access_write: got %b want 1", bus.mem_write); else n_pass++;
    reset = 1'b1;
    bus.req0 = 1'b0;
    #1;
    n_checks++; if (bus.mem_write !== 1'b0) $display("FAIL abort_write_gated: got %b want 0", bus.mem_write); else n_pass++;
    @(negedge clock);
    n_checks++; if (bus.done0 !== 1'b0) $display("FAIL abort_no_done: got %b want 0", bus.done0); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (mem[8] !== 32'h0000_1008) $display("FAIL abort_mem: got %h want 00001008", mem[8]); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    // tie after reset must go to port 0
    bus.we0 = 1'b0; bus.addr0 = 32'h0;
    bus.we1 = 1'b0; bus.addr1 = 32'h10;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    first_port = -1; first_cyc = -1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (first_port < 0 && bus.done0 === 1'b1) begin first_port = 0; first_cyc = c; end
      if (first_port < 0 && bus.done1 === 1'b1) begin first_port = 1; first_cyc = c; end
      if (first_port >= 0) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (first_port !== 0) $display("FAIL abort_next_grant: got %0d want 0", first_port); else n_pass++;
    n_checks++; if (first_cyc !== 2) $display("FAIL abort_next_latency: got %0d want 2", first_cyc); else n_pass++;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    test_reset();
    test_read();
    test_write_readback();
    test_errors();
    test_contention();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_data_mem_arbiter
`default_nettype wire
